// File: rtl/k10_muldiv.sv
// k10_muldiv: iterative radix-2 RV32M multiply/divide unit for the EX stage
module k10_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  input  logic            i_stall,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op;
  logic neg_res, neg_rem;
  logic [XLEN-1:0] opnd;
  logic [2*XLEN-1:0] acc, acc_nx, prod;
  logic [4:0] cnt;
  logic is_div, s1, s2, div_zero, ovf, special;
  logic [XLEN-1:0] abs1, abs2, spec_res, quo, rem, res;
  logic [XLEN:0] sum, diff;
  assign is_div = i_op[2];
  assign s1 = (i_op inside {3'd1, 3'd2, 3'd4, 3'd6}) && i_rs1[XLEN-1];
  assign s2 = (i_op inside {3'd1, 3'd4, 3'd6}) && i_rs2[XLEN-1];
  assign abs1 = s1 ? -i_rs1 : i_rs1;
  assign abs2 = s2 ? -i_rs2 : i_rs2;
  assign div_zero = is_div && i_rs2 == '0;
  assign ovf = is_div && !i_op[0] && i_rs1 == {1'b1, {(XLEN-1){1'b0}}} && i_rs2 == '1;
  assign special = div_zero || ovf;
  assign spec_res = div_zero ? (i_op[1] ? i_rs1 : '1) : (i_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
  // Multiply keeps the multiplier in acc's low half; divide keeps the dividend there.
  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    acc_nx = op[2] ? (diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                   : {sum, acc[XLEN-1:1]};
    prod = neg_res ? -acc_nx : acc_nx;
    quo = neg_res ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    rem = neg_rem ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
    res = !op[2] ? (op[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) : (op[1] ? rem : quo);
  end
  always_comb begin
    state_nx = i_flush ? IDLE
             : state == IDLE ? (i_valid ? (special ? DONE : CALC) : IDLE)
             : state == CALC ? (cnt == 5'd31 ? DONE : CALC)
             : (i_stall ? DONE : IDLE);
  end
  assign o_busy = !i_flush && (state == CALC || (state == IDLE && i_valid));
  assign o_done = !i_flush && state == DONE;
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      opnd <= '0;
      acc <= '0;
      cnt <= '0;
      o_result <= '0;
    end else if (state == IDLE && i_valid && !i_flush) begin
      op <= i_op;
      neg_res <= s1 ^ s2;
      neg_rem <= s1;
      opnd <= is_div ? abs2 : abs1;
      acc <= {{XLEN{1'b0}}, is_div ? abs1 : abs2};
      cnt <= '0;
      if (special) o_result <= spec_res;
    end else if (state == CALC && !i_flush) begin
      acc <= acc_nx;
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) o_result <= res;
    end
  end
endmodule
